fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO. It is the next-generation storage block behind the lab testbench interface, generalised from the fixed FIFO in width, depth and status reporting. It adds programmable almost-full/almost-empty thresholds, an occupancy count, and overflow/underflow error pulses. An optional first-word-fall-through read mode is selected at compile time.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH-1)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (1..DEPTH-1)

Ports (AW = $clog2(DEPTH)):
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- data_in  in  WIDTH  write data, sampled with wr_en
- rd_en  in  1  read request (standard mode) / head acknowledge (FWFT mode)
- data_out  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected because full
- underflow  out  1  one-cycle pulse: read rejected because empty

## Operation
- Storage: DEPTH×WIDTH register array. wr_ptr and rd_ptr are AW bits each and wrap naturally from DEPTH-1 to 0. count is a separate AW+1-bit register.
- Write accepted iff wr_en && !full. On acceptance: mem[wr_ptr] ← data_in, wr_ptr+1.
- Read accepted iff rd_en && !empty. On acceptance: rd_ptr+1.
- count update: +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- Flags are a combinational decode of the registered count, so there is no extra latency beyond the count register.
- Simultaneous wr_en && rd_en:
  - when full: the read is accepted and the write is rejected; overflow pulses and count goes to DEPTH-1.
  - when empty: the write is accepted and the read is rejected; underflow pulses and count goes to 1.
  - otherwise: both are accepted and count is unchanged.
- Rejected accesses change no storage, pointer or count state.
- overflow and underflow are registered. Each asserts for exactly the one cycle following the rejected request, and re-pulses on every rejected cycle.
- Reset (asynchronous, any time, including mid-burst):
  - wr_ptr = rd_ptr = count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = underflow = 0, data_out = 0.
  - Memory contents are not cleared and are not observable afterwards.

## Timing
- Write to visibility: a write accepted at edge N makes count, empty and almost_* reflect it after edge N.
- Standard mode, read latency 1: data_out is registered and loads mem[rd_ptr] at the edge where the read is accepted. It holds its value on all other cycles, including rejected reads.
- FWFT mode, read latency 0: data_out = mem[rd_ptr] whenever !empty, and 0 when empty. rd_en consumes the displayed word at the edge.
- Full to not-full: full deasserts the cycle after a read is accepted, and a write in that following cycle is accepted.
- Maximum throughput is one write and one read per cycle.

## Configuration
- FIFO_FWFT_EN: when defined, the block uses first-word-fall-through read as described under Timing. When undefined, it uses standard registered read with 1-cycle latency.
- Flag, count and error behaviour is identical in both builds.

## Test plan
Defaults: WIDTH=8, DEPTH=16, AF=14, AE=2.
- Reset, then write 0x01..0x10 with no reads:
  - count steps 1..16; almost_empty drops at count 3; almost_full rises at count 14; full at 16.
  - A 17th write (0xAA) gives a 1-cycle overflow pulse, count stays 16, and the write is not stored.
- From full, read 16 times:
  - Standard mode: data_out is 0x01..0x10 in order, each one cycle after its read.
  - Then a read on empty gives a 1-cycle underflow pulse and data_out holds 0x10.
- Simultaneous wr_en/rd_en for 40 cycles at count 8, writing an incrementing pattern:
  - count stays 8 and flags are static.
  - Read data is the written sequence delayed by 8 entries, which crosses the pointer wrap at least twice.
- Simultaneous rd_en/wr_en edge cases:
  - At full: count goes to 15, overflow pulses, the head word is read.
  - At empty: count goes to 1, underflow pulses, the written word is stored.
- Assert rst mid-burst at count 9, asynchronously between clock edges:
  - Outputs go to reset values immediately: count 0, empty 1, data_out 0.
  - After release, writing 0x5A then reading returns 0x5A.
- FIFO_FWFT_EN build:
  - After writing 0x3C to an empty FIFO, data_out = 0x3C as soon as empty deasserts.
  - Acknowledging with rd_en returns data_out to 0 and empty to 1 next cycle.

Source files
------------

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with almost-full/almost-empty thresholds,
// occupancy count and overflow/underflow pulses. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, underflow_q;
    logic             wr_acc, rd_acc;

    // Flags decode straight from the registered count: no added latency.
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
        end
    end

    // Storage is deliberately not reset; stale words are never visible through the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] data_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         data_out_q <= '0;
        else if (rd_acc) data_out_q <= mem_q[rd_ptr_q];
    end

    assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed self-checking bench for fifo_param at default parameters.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] data_in = '0;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int total = 0;
    int bad   = 0;

    fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
            bad++; $display("FAIL reset_flags got=%b exp=1100", {empty, almost_empty, full, almost_full}); end
        total++; if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", data_out); end
    endtask

    task automatic test_fill();
        logic [4:0] ec;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; data_in = 8'(i);
            tick();
            ec = 5'(i);
            total++; if (count !== ec) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, ec); end
            total++; if (almost_empty !== (i <= 2)) begin bad++; $display("FAIL fill_ae i=%0d got=%b", i, almost_empty); end
            total++; if (almost_full !== (i >= 14)) begin bad++; $display("FAIL fill_af i=%0d got=%b", i, almost_full); end
            total++; if (full !== (i == 16)) begin bad++; $display("FAIL fill_full i=%0d got=%b", i, full); end
            total++; if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, empty); end
        end
        data_in = 8'hAA;
        tick();
        wr_en = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
        tick();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_drain();
        logic [4:0] ec;
        for (int i = 1; i <= 16; i++) begin
`ifdef FIFO_FWFT_EN
            total++; if (data_out !== 8'(i)) begin bad++; $display("FAIL drain_dout i=%0d got=%h exp=%h", i, data_out, 8'(i)); end
`endif
            rd_en = 1'b1;
            tick();
            ec = 5'(16 - i);
`ifndef FIFO_FWFT_EN
            total++; if (data_out !== 8'(i)) begin bad++; $display("FAIL drain_dout i=%0d got=%h exp=%h", i, data_out, 8'(i)); end
`endif
            total++; if (count !== ec) begin bad++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, ec); end
        end
        tick();
        rd_en = 1'b0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_pulse got=%b exp=1", underflow); end
`ifdef FIFO_FWFT_EN
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL udf_dout got=%h exp=00", data_out); end
`else
        total++; if (data_out !== 8'h10) begin bad++; $display("FAIL udf_dout got=%h exp=10", data_out); end
`endif
        total++; if (count !== 5'd0) begin bad++; $display("FAIL udf_count got=%0d exp=0", count); end
        tick();
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL udf_clear got=%b exp=0", underflow); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        for (int k = 0; k < 8; k++) begin
            wr_en = 1'b1; data_in = 8'(8'h80 + k);
            tick();
        end
        for (int k = 8; k < 48; k++) begin
            exp_d = 8'(8'h80 + k - 8);
`ifdef FIFO_FWFT_EN
            total++; if (data_out !== exp_d) begin bad++; $display("FAIL b2b_dout k=%0d got=%h exp=%h", k, data_out, exp_d); end
`endif
            wr_en = 1'b1; rd_en = 1'b1; data_in = 8'(8'h80 + k);
            tick();
`ifndef FIFO_FWFT_EN
            total++; if (data_out !== exp_d) begin bad++; $display("FAIL b2b_dout k=%0d got=%h exp=%h", k, data_out, exp_d); end
`endif
            total++; if (count !== 5'd8) begin bad++; $display("FAIL b2b_count k=%0d got=%0d exp=8", k, count); end
            total++; if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b0) begin
                bad++; $display("FAIL b2b_flags k=%0d got=%b exp=000000", k,
                                {empty, almost_empty, full, almost_full, overflow, underflow}); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_simul_edges();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; data_in = 8'(8'h20 + i);
            tick();
        end
`ifdef FIFO_FWFT_EN
        total++; if (data_out !== 8'h20) begin bad++; $display("FAIL full_rw_head got=%h exp=20", data_out); end
`endif
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hEE;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        total++; if (count !== 5'd15) begin bad++; $display("FAIL full_rw_count got=%0d exp=15", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_rw_ovf got=%b exp=1", overflow); end
`ifdef FIFO_FWFT_EN
        total++; if (data_out !== 8'h21) begin bad++; $display("FAIL full_rw_next got=%h exp=21", data_out); end
`else
        total++; if (data_out !== 8'h20) begin bad++; $display("FAIL full_rw_head got=%h exp=20", data_out); end
`endif

        do_reset();
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        total++; if (count !== 5'd1) begin bad++; $display("FAIL empty_rw_count got=%0d exp=1", count); end
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL empty_rw_udf got=%b exp=1", underflow); end
`ifdef FIFO_FWFT_EN
        total++; if (data_out !== 8'h77) begin bad++; $display("FAIL empty_rw_data got=%h exp=77", data_out); end
`else
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL empty_rw_hold got=%h exp=00", data_out); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++; if (data_out !== 8'h77) begin bad++; $display("FAIL empty_rw_data got=%h exp=77", data_out); end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; data_in = 8'(8'h41 + i);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        total++; if (count !== 5'd9) begin bad++; $display("FAIL ar_pre_count got=%0d exp=9", count); end
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h99;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL ar_empty got=%b exp=1", empty); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL ar_dout got=%h exp=00", data_out); end
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        rst = 1'b0;
        wr_en = 1'b1; data_in = 8'h5A;
        tick();
        wr_en = 1'b0;
`ifdef FIFO_FWFT_EN
        total++; if (data_out !== 8'h5A) begin bad++; $display("FAIL ar_readback got=%h exp=5a", data_out); end
`endif
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`ifndef FIFO_FWFT_EN
        total++; if (data_out !== 8'h5A) begin bad++; $display("FAIL ar_readback got=%h exp=5a", data_out); end
`endif
        total++; if (count !== 5'd0) begin bad++; $display("FAIL ar_post_count got=%0d exp=0", count); end
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_fwft();
        do_reset();
        wr_en = 1'b1; data_in = 8'h3C;
        tick();
        wr_en = 1'b0;
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL fwft_empty got=%b exp=0", empty); end
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL fwft_show got=%h exp=3c", data_out); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL fwft_ack got=%h exp=00", data_out); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fwft_ack_empty got=%b exp=1", empty); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_simul_edges();
        test_async_reset();
`ifdef FIFO_FWFT_EN
        test_fwft();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
